dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width.
REQ-003 SHALL have parameter MAX_BURST, default 16, maximum DMA burst length in beats.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports core_req, core_we  input  1  core access request and write flag.
REQ-007 SHALL have ports core_wen / core_strctrl  input  4 / 3  core byte enables and store control.
REQ-008 SHALL have ports core_addr, core_din  input  ADDR_W, DATA_W  core address and write data.
REQ-009 SHALL have ports core_hold, core_rvalid  output  1  core stall and read-data-valid.
REQ-010 SHALL have ports ras_req, ras_we  input  1, and ras_addr, ras_din  input  ADDR_W, DATA_W  return-address-stack spill/fill port.
REQ-011 SHALL have ports ras_gnt, ras_rvalid  output  1  RAS grant and read-data-valid.
REQ-012 SHALL have ports dma_req, dma_we  input  1, dma_addr, dma_din  input  ADDR_W, DATA_W, and dma_len  input  $clog2(MAX_BURST)+1  DMA burst request.
REQ-013 SHALL have ports dma_gnt, dma_rvalid, dma_done  output  1  per-beat grant, read valid, burst-complete pulse.
REQ-014 SHALL have ports mem_en, mem_wea  output  1, mem_wen  output  4, mem_strctrl  output  3, mem_addr  output  ADDR_W, mem_din  output  DATA_W  shared memory port.
REQ-015 SHALL have ports mem_dout  input  DATA_W, and rd_dout  output  DATA_W  read data, returned to all requesters, qualified by the per-requester rvalid.

Function
REQ-016 SHALL implement FSM with states IDLE, CORE, RAS, DMA_BURST; exactly one owner drives mem_* each cycle; mem_en=0 in IDLE.
REQ-017 SHALL arbitrate in IDLE/CORE/RAS each cycle, fixed priority core > ras > dma; grant is combinational in the requesting cycle.
REQ-018 SHALL assert core_hold=1 in any cycle core_req=1 and the core is not granted; otherwise 0.
REQ-019 SHALL pass RAS writes with mem_wen=4'b1111, mem_strctrl=3'b100; RAS reads with mem_wen=0, mem_strctrl=3'b000; DMA uses the same encoding.
REQ-020 SHALL, on DMA grant from IDLE, latch dma_len (0 treated as 1) into a beat counter and enter DMA_BURST; the counter decrements per granted beat (dma_gnt=1 while dma_req=1).
REQ-021 SHALL in DMA_BURST hold ownership to DMA (core_hold=1 on core_req, ras_gnt=0) until the final beat; dma_done pulses 1 cycle in the cycle after the final beat; the FSM then returns to IDLE.
REQ-022 SHALL, if dma_req drops mid-burst, insert idle beats (mem_en=0) without releasing ownership; the counter is not decremented.
REQ-023 SHALL provide read data at a fixed latency of 1 cycle: a one-entry owner tag registers the owner of each read; the matching *_rvalid=1 the next cycle with rd_dout=mem_dout; writes produce no rvalid.
REQ-024 SHALL, for simultaneous core and ras requests with STARVE disabled, grant core and leave ras_gnt=0.

Reset
REQ-025 SHALL, on Rst=1 (asynchronous, including mid-burst), force state IDLE, beat counter 0, owner tag none, and starve counter 0.
REQ-026 SHALL hold all outputs 0 while Rst=1 and in the first cycle after reset release, except where a core_req grant drives mem_* combinationally.
REQ-027 SHALL not produce a dma_done pulse for a burst aborted by reset.

Configuration
REQ-028 SHALL, with DMEM_ARB_STARVE_EN defined, count consecutive cycles ras_req=1 && ras_gnt=0 (saturating); at STARVE_LIMIT the next arbitration grants RAS over core (core_hold=1) and the counter clears.
REQ-029 SHALL, without DMEM_ARB_STARVE_EN, implement strict priority with no counter logic.

Structure
REQ-030 SHALL place owner_e (NONE, CORE, RAS, DMA), state_e, and STARVE_LIMIT=8 in package dmem_arb_pkg.
REQ-031 SHALL implement the burst beat counter as sub-module dmem_arb_burst_cnt (load, dec, last, zero).

Verification
REQ-032 SHALL verify: core read 0x00010004 alone -> mem_en=1 same cycle; core_rvalid=1 next cycle with rd_dout=mem_dout; core_hold=0.
REQ-033 SHALL verify: core_req and ras_req held together 10 cycles, STARVE enabled -> ras_gnt=1 on cycle 9 with core_hold=1 that cycle; disabled -> ras_gnt never asserted.
REQ-034 SHALL verify: DMA write with dma_len=4 and core_req asserted after beat 1 -> 4 beats with mem_wen=4'b1111, core_hold=1 throughout, dma_done one cycle after beat 4, core granted next.
REQ-035 SHALL verify: DMA burst with dma_len=3 and dma_req deasserted 2 cycles mid-burst -> 2 idle cycles, still 3 beats total, single dma_done.
REQ-036 SHALL verify: Rst asserted asynchronously during beat 2 of an 8-beat burst -> immediate IDLE, all outputs 0, no dma_done, core served first cycle after release.
REQ-037 SHALL verify: dma_len=0 -> exactly one beat and dma_done.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int STARVE_LIMIT = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CORE      = 2'd1;
  localparam logic [1:0] ST_RAS       = 2'd2;
  localparam logic [1:0] ST_DMA_BURST = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_CORE      = ST_CORE,
    S_RAS       = ST_RAS,
    S_DMA_BURST = ST_DMA_BURST
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_RAS  = 2'd2,
    OWN_DMA  = 2'd3
  } owner_e;

  localparam logic [3:0] WEN_FULL = 4'b1111;
  localparam logic [2:0] STR_WORD = 3'b100;

  // RAS and DMA only ever move full words
  function automatic logic [3:0] word_wen(input logic we);
    return we ? WEN_FULL : 4'b0000;
  endfunction

  function automatic logic [2:0] word_str(input logic we);
    return we ? STR_WORD : 3'b000;
  endfunction

endpackage

// File: rtl/dmem_arb_burst_cnt.sv
// Remaining-beat counter for a DMA burst; a load that coincides with a beat counts that beat.
module dmem_arb_burst_cnt #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic         i_dec,
  input  logic [W-1:0] i_len,
  output logic         o_last,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_dec ? i_len - W'(1) : i_len;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_last = (r_cnt == W'(1));
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between core, RAS spill/fill and DMA bursts (core > ras > dma).
// Define DMEM_ARB_STARVE_EN to let a starved RAS requester preempt the core once.
//
// state       | meaning
// S_IDLE      | nobody owned the port last cycle; arbitrate
// S_CORE      | core owned the port last cycle; arbitrate
// S_RAS       | RAS owned the port last cycle; arbitrate
// S_DMA_BURST | DMA owns the port until its burst completes, incl. the done cycle
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       Rst,
  input  logic                       core_req,
  input  logic                       core_we,
  input  logic [3:0]                 core_wen,
  input  logic [2:0]                 core_strctrl,
  input  logic [ADDR_W-1:0]          core_addr,
  input  logic [DATA_W-1:0]          core_din,
  output logic                       core_hold,
  output logic                       core_rvalid,
  input  logic                       ras_req,
  input  logic                       ras_we,
  input  logic [ADDR_W-1:0]          ras_addr,
  input  logic [DATA_W-1:0]          ras_din,
  output logic                       ras_gnt,
  output logic                       ras_rvalid,
  input  logic                       dma_req,
  input  logic                       dma_we,
  input  logic [ADDR_W-1:0]          dma_addr,
  input  logic [DATA_W-1:0]          dma_din,
  input  logic [$clog2(MAX_BURST):0] dma_len,
  output logic                       dma_gnt,
  output logic                       dma_rvalid,
  output logic                       dma_done,
  output logic                       mem_en,
  output logic                       mem_wea,
  output logic [3:0]                 mem_wen,
  output logic [2:0]                 mem_strctrl,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_din,
  input  logic [DATA_W-1:0]          mem_dout,
  output logic [DATA_W-1:0]          rd_dout
);

  localparam int LEN_W = $clog2(MAX_BURST) + 1;

  state_e             r_state;
  state_e             w_state_nxt;
  owner_e             w_owner;
  owner_e             r_tag;
  logic               r_done;
  logic               w_ras_boost;
  logic               w_dma_start;
  logic               w_dma_beat;
  logic               w_final_beat;
  logic               w_cnt_last;
  logic               w_cnt_zero;
  logic [LEN_W-1:0]   w_len_eff;

`ifdef DMEM_ARB_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LP_STARVE = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_starve <= '0;
    end else if (!ras_req || ras_gnt) begin
      r_starve <= '0;
    end else if (r_starve != LP_STARVE) begin
      r_starve <= r_starve + SW'(1);
    end
  end

  assign w_ras_boost = ras_req && (r_starve == LP_STARVE);
`else
  assign w_ras_boost = 1'b0;
`endif

  always_comb begin
    w_owner = OWN_NONE;
    if (!Rst) begin
      if (r_state == S_DMA_BURST) begin
        if (!w_cnt_zero && dma_req) w_owner = OWN_DMA;
      end else if (w_ras_boost) begin
        w_owner = OWN_RAS;
      end else if (core_req) begin
        w_owner = OWN_CORE;
      end else if (ras_req) begin
        w_owner = OWN_RAS;
      end else if (dma_req) begin
        w_owner = OWN_DMA;
      end
    end
  end

  assign w_len_eff    = (dma_len == '0) ? LEN_W'(1) : dma_len;
  assign w_dma_beat   = (w_owner == OWN_DMA);
  assign w_dma_start  = w_dma_beat && (r_state != S_DMA_BURST);
  assign w_final_beat = w_dma_beat &&
                        (w_dma_start ? (w_len_eff == LEN_W'(1)) : w_cnt_last);

  dmem_arb_burst_cnt #(.W(LEN_W)) u_burst_cnt (
    .clk    (clk),
    .rst    (Rst),
    .i_load (w_dma_start),
    .i_dec  (w_dma_beat),
    .i_len  (w_len_eff),
    .o_last (w_cnt_last),
    .o_zero (w_cnt_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_DMA_BURST) begin
      if (w_cnt_zero) w_state_nxt = S_IDLE;
    end else begin
      case (w_owner)
        OWN_CORE: w_state_nxt = S_CORE;
        OWN_RAS:  w_state_nxt = S_RAS;
        OWN_DMA:  w_state_nxt = S_DMA_BURST;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en      = 1'b0;
    mem_wea     = 1'b0;
    mem_wen     = 4'b0000;
    mem_strctrl = 3'b000;
    mem_addr    = '0;
    mem_din     = '0;
    case (w_owner)
      OWN_CORE: begin
        mem_en      = 1'b1;
        mem_wea     = core_we;
        mem_wen     = core_wen;
        mem_strctrl = core_strctrl;
        mem_addr    = core_addr;
        mem_din     = core_din;
      end
      OWN_RAS: begin
        mem_en      = 1'b1;
        mem_wea     = ras_we;
        mem_wen     = word_wen(ras_we);
        mem_strctrl = word_str(ras_we);
        mem_addr    = ras_addr;
        mem_din     = ras_din;
      end
      OWN_DMA: begin
        mem_en      = 1'b1;
        mem_wea     = dma_we;
        mem_wen     = word_wen(dma_we);
        mem_strctrl = word_str(dma_we);
        mem_addr    = dma_addr;
        mem_din     = dma_din;
      end
      default: ;
    endcase
  end

  // r_done fires the cycle after the final beat; reset kills it so aborted bursts never complete
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_tag   <= OWN_NONE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= (mem_en && !mem_wea) ? w_owner : OWN_NONE;
      r_done  <= w_final_beat;
    end
  end

  assign core_hold   = !Rst && core_req && (w_owner != OWN_CORE);
  assign ras_gnt     = (w_owner == OWN_RAS);
  assign dma_gnt     = w_dma_beat;
  assign dma_done    = r_done;
  assign core_rvalid = (r_tag == OWN_CORE);
  assign ras_rvalid  = (r_tag == OWN_RAS);
  assign dma_rvalid  = (r_tag == OWN_DMA);
  assign rd_dout     = (r_tag != OWN_NONE) ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle-by-cycle model comparison plus literal scenario checks.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        Rst = 1'b1;
  logic        core_req = 0, core_we = 0;
  logic [3:0]  core_wen = 0;
  logic [2:0]  core_strctrl = 0;
  logic [31:0] core_addr = 0, core_din = 0;
  logic        core_hold, core_rvalid;
  logic        ras_req = 0, ras_we = 0;
  logic [31:0] ras_addr = 0, ras_din = 0;
  logic        ras_gnt, ras_rvalid;
  logic        dma_req = 0, dma_we = 0;
  logic [31:0] dma_addr = 0, dma_din = 0;
  logic [4:0]  dma_len = 0;
  logic        dma_gnt, dma_rvalid, dma_done;
  logic        mem_en, mem_wea;
  logic [3:0]  mem_wen;
  logic [2:0]  mem_strctrl;
  logic [31:0] mem_addr, mem_din;
  logic [31:0] mem_dout = 32'h0;
  logic [31:0] rd_dout;

  dmem_arbiter dut (
    .clk(clk), .Rst(Rst),
    .core_req(core_req), .core_we(core_we), .core_wen(core_wen), .core_strctrl(core_strctrl),
    .core_addr(core_addr), .core_din(core_din), .core_hold(core_hold), .core_rvalid(core_rvalid),
    .ras_req(ras_req), .ras_we(ras_we), .ras_addr(ras_addr), .ras_din(ras_din),
    .ras_gnt(ras_gnt), .ras_rvalid(ras_rvalid),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din), .dma_len(dma_len),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_done(dma_done),
    .mem_en(mem_en), .mem_wea(mem_wea), .mem_wen(mem_wen), .mem_strctrl(mem_strctrl),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .rd_dout(rd_dout)
  );

  always #5 clk = ~clk;

  // memory returns a scrambled address one cycle after a read
  always @(posedge clk) if (mem_en && !mem_wea) mem_dout <= mem_addr ^ 32'hDEADBEEF;

  int n_tests = 0, n_fail = 0;

  // model state: owner codes 0 none, 1 core, 2 ras, 3 dma
  bit          m_burst = 0;
  int          m_left = 0;
  int          m_starve = 0;
  int          m_rd_own = 0;
  logic [31:0] m_rd_addr = 0;

  function automatic int exp_owner();
    if (Rst) return 0;
    if (m_burst) return (m_left > 0 && dma_req) ? 3 : 0;
`ifdef DMEM_ARB_STARVE_EN
    if (ras_req && m_starve >= 8) return 2;
`endif
    if (core_req) return 1;
    if (ras_req) return 2;
    if (dma_req) return 3;
    return 0;
  endfunction

  function automatic logic [111:0] exp_vec();
    int o;
    logic en, wea, hold;
    logic [3:0] wen;
    logic [2:0] st;
    logic [31:0] a, d;
    o = exp_owner();
    en = 0; wea = 0; wen = 0; st = 0; a = 0; d = 0;
    case (o)
      1: begin en = 1; wea = core_we; wen = core_wen; st = core_strctrl; a = core_addr; d = core_din; end
      2: begin en = 1; wea = ras_we; wen = ras_we ? 4'hF : 4'h0; st = ras_we ? 3'b100 : 3'b000;
               a = ras_addr; d = ras_din; end
      3: begin en = 1; wea = dma_we; wen = dma_we ? 4'hF : 4'h0; st = dma_we ? 3'b100 : 3'b000;
               a = dma_addr; d = dma_din; end
      default: ;
    endcase
    hold = !Rst && core_req && (o != 1);
    return {hold, m_rd_own == 1, o == 2, m_rd_own == 2, o == 3, m_rd_own == 3,
            !Rst && m_burst && m_left == 0, en, wea, wen, st, a, d,
            (m_rd_own != 0) ? (m_rd_addr ^ 32'hDEADBEEF) : 32'h0};
  endfunction

  always @(posedge clk or posedge Rst) begin
    if (Rst) begin
      m_burst = 0; m_left = 0; m_starve = 0; m_rd_own = 0;
    end else begin
      int o;
      bit rd;
      logic [31:0] ra;
      o = exp_owner();
      rd = 0; ra = 0;
      case (o)
        1: begin rd = !core_we; ra = core_addr; end
        2: begin rd = !ras_we;  ra = ras_addr;  end
        3: begin rd = !dma_we;  ra = dma_addr;  end
        default: ;
      endcase
      m_rd_own  = rd ? o : 0;
      m_rd_addr = ra;
      if (ras_req && o != 2) m_starve = (m_starve < 8) ? m_starve + 1 : 8;
      else m_starve = 0;
      if (m_burst) begin
        if (m_left == 0) m_burst = 0;
        else if (dma_req) m_left = m_left - 1;
      end else if (o == 3) begin
        m_burst = 1;
        m_left  = ((dma_len == 0) ? 1 : int'(dma_len)) - 1;
      end
    end
  end

  int cyc = 0, beat_cnt = 0, wen_full_cnt = 0, done_cnt = 0, hold_cnt = 0, idle_cnt = 0;
  int last_beat_cyc = 0, done_cyc = 0;
  bit win = 0;

  always @(negedge clk) begin
    logic [111:0] a_v, e_v;
    a_v = {core_hold, core_rvalid, ras_gnt, ras_rvalid, dma_gnt, dma_rvalid, dma_done,
           mem_en, mem_wea, mem_wen, mem_strctrl, mem_addr, mem_din, rd_dout};
    e_v = exp_vec();
    n_tests++;
    if (a_v !== e_v) begin
      n_fail++;
      $display("FAIL cycle_outputs cyc=%0d got %h want %h", cyc, a_v, e_v);
    end
    cyc++;
    beat_cnt     += int'(dma_gnt);
    wen_full_cnt += int'(dma_gnt && mem_wen == 4'hF);
    done_cnt     += int'(dma_done);
    hold_cnt     += int'(core_hold);
    idle_cnt     += int'(win && !mem_en && !dma_done);
    if (dma_gnt)  last_beat_cyc = cyc;
    if (dma_done) done_cyc = cyc;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic to_neg(); @(negedge clk); #1; endtask
  task automatic to_pos(); @(posedge clk); #1; endtask
  task automatic step(); to_neg(); to_pos(); endtask

  task automatic clr();
    beat_cnt = 0; wen_full_cnt = 0; done_cnt = 0; hold_cnt = 0; idle_cnt = 0;
    last_beat_cyc = 0; done_cyc = 0;
  endtask

  int ras_first;

  initial begin
    // reset: outputs quiet even with a pending core request
    core_req = 1; core_addr = 32'h00010004;
    to_neg();
    chk("rst_core_hold", core_hold, 0);
    chk("rst_mem_en", mem_en, 0);
    to_pos();
    step();
    Rst = 0; core_req = 0;
    to_neg(); chk("post_rst_mem_en", mem_en, 0); to_pos();

    // lone core read
    core_req = 1; core_we = 0; core_addr = 32'h00010004; core_wen = 4'h0; core_strctrl = 3'b010;
    to_neg();
    chk("core_rd_en", mem_en, 1);
    chk("core_rd_addr", mem_addr, 32'h00010004);
    chk("core_rd_hold", core_hold, 0);
    to_pos();
    core_req = 0;
    to_neg();
    chk("core_rvalid", core_rvalid, 1);
    chk("core_rd_dout", rd_dout, 32'hDEACBEEB);
    to_pos();

    // core write collides with RAS write, then RAS write and read alone
    core_req = 1; core_we = 1; core_wen = 4'b0011; core_strctrl = 3'b001; core_din = 32'h1234;
    ras_req = 1; ras_we = 1; ras_addr = 32'h80; ras_din = 32'hCAFE;
    to_neg();
    chk("collide_ras_gnt", ras_gnt, 0);
    chk("collide_wen", mem_wen, 4'b0011);
    to_pos();
    core_req = 0; core_we = 0;
    to_neg();
    chk("ras_wr_wen", mem_wen, 4'hF);
    chk("ras_wr_str", mem_strctrl, 3'b100);
    to_pos();
    ras_we = 0; ras_addr = 32'h40;
    to_neg(); chk("ras_rd_wen", mem_wen, 4'h0); to_pos();
    ras_req = 0;
    to_neg(); chk("ras_rvalid", ras_rvalid, 1); to_pos();

    // DMA read of two beats
    clr();
    dma_req = 1; dma_we = 0; dma_len = 2; dma_addr = 32'h200;
    step(); step();
    dma_req = 0;
    step(); step();
    chk("dma_rd2_beats", beat_cnt, 2);
    chk("dma_rd2_done", done_cnt, 1);

    // core and RAS held together for ten cycles
    core_req = 1; core_we = 0; core_addr = 32'h100; ras_req = 1; ras_we = 0; ras_addr = 32'h180;
    ras_first = 0;
    for (int i = 1; i <= 10; i++) begin
      to_neg();
      if (ras_gnt && ras_first == 0) begin
        ras_first = i;
        chk("starve_core_hold", core_hold, 1);
      end
      to_pos();
    end
`ifdef DMEM_ARB_STARVE_EN
    chk("starve_ras_cycle", ras_first, 9);
`else
    chk("strict_ras_never", ras_first, 0);
`endif
    core_req = 0; ras_req = 0;
    step();

    // DMA write of 4 beats, core arrives after beat 1
    clr();
    dma_req = 1; dma_we = 1; dma_len = 4; dma_addr = 32'h300; dma_din = 32'h55;
    step();
    core_req = 1; core_we = 0; core_addr = 32'h10;
    step(); step(); step();
    dma_req = 0;
    to_neg();
    chk("b4_done", dma_done, 1);
    chk("b4_done_hold", core_hold, 1);
    to_pos();
    to_neg();
    chk("b4_core_after_hold", core_hold, 0);
    chk("b4_core_after_addr", mem_addr, 32'h10);
    to_pos();
    core_req = 0;
    chk("b4_beats", beat_cnt, 4);
    chk("b4_wen_full", wen_full_cnt, 4);
    chk("b4_done_cnt", done_cnt, 1);
    chk("b4_done_gap", done_cyc - last_beat_cyc, 1);
    chk("b4_hold_cycles", hold_cnt, 4);
    step();

    // 3-beat DMA read with a two-cycle request gap
    clr();
    win = 1;
    dma_req = 1; dma_we = 0; dma_len = 3; dma_addr = 32'h400;
    step(); step();
    dma_req = 0;
    step(); step();
    dma_req = 1;
    step();
    dma_req = 0;
    to_neg(); chk("gap_done", dma_done, 1); to_pos();
    win = 0;
    step(); step();
    chk("gap_beats", beat_cnt, 3);
    chk("gap_idle", idle_cnt, 2);
    chk("gap_done_cnt", done_cnt, 1);

    // reset during beat 2 of an 8-beat burst
    clr();
    dma_req = 1; dma_we = 1; dma_len = 8; dma_addr = 32'h500;
    step();
    chk("abort_beat2_live", dma_gnt, 1);
    #2 Rst = 1;
    #1;
    chk("abort_mem_en", mem_en, 0);
    chk("abort_dma_gnt", dma_gnt, 0);
    dma_req = 0; core_req = 1; core_we = 0; core_addr = 32'h20;
    step(); step();
    Rst = 0;
    to_neg();
    chk("abort_core_en", mem_en, 1);
    chk("abort_core_hold", core_hold, 0);
    chk("abort_core_addr", mem_addr, 32'h20);
    to_pos();
    core_req = 0;
    step(); step(); step();
    chk("abort_no_done", done_cnt, 0);

    // zero length behaves as one beat
    clr();
    dma_req = 1; dma_we = 1; dma_len = 0; dma_addr = 32'h600;
    step();
    dma_req = 0;
    step(); step(); step();
    chk("len0_beats", beat_cnt, 1);
    chk("len0_done", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
